// File: rtl/ir_multi_channel_setter.sv
// ir_multi_channel_setter
// Turns decoded IR remote key codes into per-channel duration settings for the
// traffic-light phase timer.
// Ports:
//   CLOCK_50     in   single clock
//   reset        in   synchronous, active-high
//   key_valid    in   one-cycle strobe, key_code valid
//   key_code     in   decoded IR command byte
//   enable       in   0: keys ignored, any entry abandoned
//   start        in   1: sequence running, channel change locked
//   ch_sel       out  one-hot selected channel
//   dur_bus      out  channel k duration at [k*VAL_W +: VAL_W]
//   edit_val     out  value being typed (preview), 0 when idle
//   editing      out  high while a multi-digit entry is in progress
//   commit_pulse out  one-cycle pulse when a channel register is written
module ir_multi_channel_setter #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned VAL_W       = 7,
    parameter int unsigned DIGITS      = 2,
    parameter int unsigned MAX_VAL     = 99,
    parameter int unsigned DEFAULT_VAL = 10,
    parameter int unsigned TIMEOUT_CYC = 150000000
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      key_valid,
    input  logic [7:0]                key_code,
    input  logic                      enable,
    input  logic                      start,
    output logic [NUM_CH-1:0]         ch_sel,
    output logic [NUM_CH*VAL_W-1:0]   dur_bus,
    output logic [VAL_W-1:0]          edit_val,
    output logic                      editing,
    output logic                      commit_pulse
);

    localparam int unsigned AccW  = $clog2(10 ** DIGITS);
    localparam int unsigned DcntW = $clog2(DIGITS) + 1;
    localparam int unsigned TmrW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] KeyUp     = 8'h1B;
    localparam logic [7:0] KeyDown   = 8'h1F;
    localparam logic [7:0] KeyNext   = 8'h1A;
    localparam logic [7:0] KeyPrev   = 8'h1E;
    localparam logic [7:0] KeyEnter  = 8'h17;
    localparam logic [7:0] KeyCancel = 8'h16;

    typedef enum logic [0:0] {StIdle, StEntry} state_e;

    state_e                          state_q, state_d;
    logic [AccW-1:0]                 acc_q, acc_d;
    logic [DcntW-1:0]                dcnt_q, dcnt_d;
    logic [TmrW-1:0]                 tmr_q, tmr_d;
    logic [NUM_CH-1:0]               ch_sel_q, ch_sel_d;
    logic [NUM_CH-1:0][VAL_W-1:0]    dur_q, dur_d;
    logic [VAL_W-1:0]                edit_val_q, edit_val_d;
    logic                            commit_q, commit_d;

    logic                            key_act;
    logic                            is_digit;
    logic                            is_known;
    logic [31:0]                     acc_ext;
    logic [VAL_W-1:0]                sel_val;
    logic                            do_commit;
    logic [VAL_W-1:0]                commit_val;

    function automatic logic [VAL_W-1:0] sat_val(input logic [31:0] v);
        if (v > MAX_VAL) begin
            return VAL_W'(MAX_VAL);
        end
        return v[VAL_W-1:0];
    endfunction

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        dcnt_d     = dcnt_q;
        tmr_d      = tmr_q;
        ch_sel_d   = ch_sel_q;
        dur_d      = dur_q;
        do_commit  = 1'b0;
        commit_val = '0;

        key_act  = enable && key_valid;
        is_digit = key_code <= 8'h09;
        // Unknown codes must not touch the timeout counter.
        is_known = is_digit || key_code == KeyUp || key_code == KeyDown ||
                   key_code == KeyNext || key_code == KeyPrev ||
                   key_code == KeyEnter || key_code == KeyCancel;
        acc_ext  = 32'(acc_q) * 32'd10 + 32'(key_code[3:0]);

        sel_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch_sel_q[k]) begin
                sel_val = sel_val | dur_q[k];
            end
        end

        unique case (state_q)
            StIdle: begin
                if (key_act) begin
                    if (is_digit) begin
                        if (DIGITS == 1) begin
                            do_commit  = 1'b1;
                            commit_val = sat_val(32'(key_code[3:0]));
                        end else begin
                            state_d = StEntry;
                            acc_d   = AccW'(key_code[3:0]);
                            dcnt_d  = DcntW'(1);
                            tmr_d   = '0;
                        end
                    end else if (key_code == KeyUp) begin
                        do_commit  = 1'b1;
                        commit_val = (sel_val == VAL_W'(MAX_VAL)) ? '0 : sel_val + VAL_W'(1);
                    end else if (key_code == KeyDown) begin
                        do_commit  = 1'b1;
                        commit_val = (sel_val == '0) ? VAL_W'(MAX_VAL) : sel_val - VAL_W'(1);
                    end else if (key_code == KeyNext && !start) begin
                        ch_sel_d = {ch_sel_q[NUM_CH-2:0], ch_sel_q[NUM_CH-1]};
                    end else if (key_code == KeyPrev && !start) begin
                        ch_sel_d = {ch_sel_q[0], ch_sel_q[NUM_CH-1:1]};
                    end
                end
            end
            StEntry: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (key_valid && is_known) begin
                    tmr_d = '0;
                    if (is_digit) begin
                        if (dcnt_q < DcntW'(DIGITS - 1)) begin
                            acc_d  = acc_ext[AccW-1:0];
                            dcnt_d = dcnt_q + DcntW'(1);
                        end else begin
                            do_commit  = 1'b1;
                            commit_val = sat_val(acc_ext);
                            state_d    = StIdle;
                        end
                    end else if (key_code == KeyEnter) begin
                        do_commit  = 1'b1;
                        commit_val = sat_val(32'(acc_q));
                        state_d    = StIdle;
                    end else if (key_code == KeyCancel) begin
                        state_d = StIdle;
                    end
                end else if (tmr_q == TmrW'(TIMEOUT_CYC - 1)) begin
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + TmrW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d == StIdle) begin
            acc_d  = '0;
            dcnt_d = '0;
            tmr_d  = '0;
        end

        if (do_commit) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (ch_sel_q[k]) begin
                    dur_d[k] = commit_val;
                end
            end
        end
        commit_d   = do_commit;
        edit_val_d = (state_d == StEntry) ? sat_val(32'(acc_d)) : '0;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            dcnt_q     <= '0;
            tmr_q      <= '0;
            ch_sel_q   <= NUM_CH'(1);
            for (int k = 0; k < NUM_CH; k++) begin
                dur_q[k] <= VAL_W'(DEFAULT_VAL);
            end
            edit_val_q <= '0;
            commit_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            dcnt_q     <= dcnt_d;
            tmr_q      <= tmr_d;
            ch_sel_q   <= ch_sel_d;
            dur_q      <= dur_d;
            edit_val_q <= edit_val_d;
            commit_q   <= commit_d;
        end
    end

    assign ch_sel       = ch_sel_q;
    assign dur_bus      = dur_q;
    assign edit_val     = edit_val_q;
    assign editing      = (state_q == StEntry);
    assign commit_pulse = commit_q;

endmodule

// File: tb/tb_ir_multi_channel_setter.sv
// Directed bench for ir_multi_channel_setter. Two instances share all inputs:
// dut (MAX_VAL=99) and dut60 (MAX_VAL=60), both with a 100-cycle timeout.
module tb_ir_multi_channel_setter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'hFF;
    logic        enable = 1'b1;
    logic        start = 1'b0;

    logic [2:0]  ch_sel, ch_sel60;
    logic [20:0] dur_bus, dur_bus60;
    logic [6:0]  edit_val, edit_val60;
    logic        editing, editing60;
    logic        commit_pulse, commit_pulse60;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ir_multi_channel_setter #(
        .NUM_CH(3), .VAL_W(7), .DIGITS(2), .MAX_VAL(99), .DEFAULT_VAL(10), .TIMEOUT_CYC(100)
    ) dut (
        .CLOCK_50(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .enable(enable), .start(start), .ch_sel(ch_sel), .dur_bus(dur_bus),
        .edit_val(edit_val), .editing(editing), .commit_pulse(commit_pulse)
    );

    ir_multi_channel_setter #(
        .NUM_CH(3), .VAL_W(7), .DIGITS(2), .MAX_VAL(60), .DEFAULT_VAL(10), .TIMEOUT_CYC(100)
    ) dut60 (
        .CLOCK_50(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
        .enable(enable), .start(start), .ch_sel(ch_sel60), .dur_bus(dur_bus60),
        .edit_val(edit_val60), .editing(editing60), .commit_pulse(commit_pulse60)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Key is sampled on the next rising edge; outputs are read 1 time unit later.
    task automatic press(input logic [7:0] c);
        key_code  = c;
        key_valid = 1'b1;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 8'hFF;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        check("rst_ch_sel", 32'(ch_sel), 32'd1);
        check("rst_dur", 32'(dur_bus), 32'({7'd10, 7'd10, 7'd10}));
        check("rst_edit_val", 32'(edit_val), 32'd0);
        check("rst_editing", 32'(editing), 32'd0);
        check("rst_commit", 32'(commit_pulse), 32'd0);

        // Two-digit entry auto-commits on the second digit.
        press(8'h04);
        check("t1_editing", 32'(editing), 32'd1);
        check("t1_edit_val", 32'(edit_val), 32'd4);
        check("t1_no_pulse", 32'(commit_pulse), 32'd0);
        press(8'h02);
        check("t1_ch0", 32'(dur_bus[6:0]), 32'd42);
        check("t1_pulse", 32'(commit_pulse), 32'd1);
        check("t1_editing_off", 32'(editing), 32'd0);
        check("t1_edit_val_off", 32'(edit_val), 32'd0);
        check("t1_others", 32'(dur_bus[20:7]), 32'({7'd10, 7'd10}));
        idle(1);
        check("t1_pulse_once", 32'(commit_pulse), 32'd0);

        // Wrap-around trimming.
        press(8'h09);
        press(8'h09);
        check("t2_ch0_99", 32'(dur_bus[6:0]), 32'd99);
        press(8'h1B);
        check("t2_up_wrap", 32'(dur_bus[6:0]), 32'd0);
        check("t2_up_pulse", 32'(commit_pulse), 32'd1);
        press(8'h1F);
        check("t2_down_wrap", 32'(dur_bus[6:0]), 32'd99);
        check("t2_down_pulse", 32'(commit_pulse), 32'd1);
        press(8'h1F);
        check("t2_down", 32'(dur_bus[6:0]), 32'd98);

        // Unknown code in idle does nothing.
        press(8'h55);
        check("unk_pulse", 32'(commit_pulse), 32'd0);
        check("unk_editing", 32'(editing), 32'd0);

        // Channel selection.
        press(8'h1A);
        check("t3_next1", 32'(ch_sel), 32'b010);
        press(8'h1A);
        check("t3_next2", 32'(ch_sel), 32'b100);
        press(8'h1A);
        check("t3_next3", 32'(ch_sel), 32'b001);
        start = 1'b1;
        press(8'h1A);
        check("t3_locked", 32'(ch_sel), 32'b001);
        start = 1'b0;
        press(8'h1E);
        check("t3_prev_wrap", 32'(ch_sel), 32'b100);
        press(8'h1E);
        check("t3_prev", 32'(ch_sel), 32'b010);

        // ENTER / CANCEL on channel 1.
        press(8'h07);
        press(8'h17);
        check("t4_enter", 32'(dur_bus[13:7]), 32'd7);
        check("t4_enter_pulse", 32'(commit_pulse), 32'd1);
        press(8'h05);
        check("t4_editing", 32'(editing), 32'd1);
        press(8'h16);
        check("t4_cancel_val", 32'(dur_bus[13:7]), 32'd7);
        check("t4_cancel_pulse", 32'(commit_pulse), 32'd0);
        check("t4_cancel_editing", 32'(editing), 32'd0);

        // Timeout: 100 idle cycles in entry abandon it.
        press(8'h03);
        idle(99);
        check("t5_still_editing", 32'(editing), 32'd1);
        idle(1);
        check("t5_timed_out", 32'(editing), 32'd0);
        check("t5_no_write", 32'(dur_bus[13:7]), 32'd7);
        check("t5_no_pulse", 32'(commit_pulse), 32'd0);

        // Key landing on the expiry cycle wins.
        press(8'h03);
        idle(99);
        press(8'h04);
        check("t5_late_key", 32'(dur_bus[13:7]), 32'd34);
        check("t5_late_pulse", 32'(commit_pulse), 32'd1);

        // enable low abandons entry and blocks keys.
        press(8'h06);
        enable = 1'b0;
        idle(1);
        check("en_abandon", 32'(editing), 32'd0);
        press(8'h1B);
        check("en_ignored", 32'(dur_bus[13:7]), 32'd34);
        check("en_ignored_pulse", 32'(commit_pulse), 32'd0);
        enable = 1'b1;

        // Saturation at MAX_VAL=60, and reset mid-entry.
        do_reset();
        press(8'h08);
        check("t6_edit_val", 32'(edit_val60), 32'd8);
        press(8'h05);
        check("t6_sat60", 32'(dur_bus60[6:0]), 32'd60);
        check("t6_sat60_pulse", 32'(commit_pulse60), 32'd1);
        check("t6_nosat99", 32'(dur_bus[6:0]), 32'd85);
        press(8'h08);
        do_reset();
        check("t6_rst_editing", 32'(editing60), 32'd0);
        check("t6_rst_ch0", 32'(dur_bus60[6:0]), 32'd10);
        press(8'h05);
        check("t6_fresh_entry", 32'(edit_val60), 32'd5);
        press(8'h17);
        check("t6_enter5", 32'(dur_bus60[6:0]), 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
